// File: rtl/cnt74190_seq_if.sv
// rtl/cnt74190_seq_if.sv - control and counter-side signal bundle for the cnt74190 sequencer
interface cnt74190_seq_if;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic       dir;
  logic [3:0] preset;
  logic [3:0] cycles;
  logic [3:0] q;
  logic       max_min;
  logic       load;
  logic       ce;
  logic       up_down;
  logic [3:0] p;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] evt_cnt;

  modport master (
    output start, stop, mode, dir, preset, cycles, q, max_min,
    input  load, ce, up_down, p, busy, done, err, evt_cnt
  );

  modport slave (
    input  start, stop, mode, dir, preset, cycles, q, max_min,
    output load, ce, up_down, p, busy, done, err, evt_cnt
  );
endinterface

// File: rtl/cnt74190_seq.sv
// rtl/cnt74190_seq.sv - programmable timer sequencer driving one cnt74190 BCD counter
module cnt74190_seq (
  input  logic          clk_i,
  input  logic          rst_i,
  cnt74190_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_BOUNCE   = 2'b10;
  localparam logic [1:0] MODE_FREE     = 2'b11;

  state_e     state_q;
  logic [1:0] mode_q;
  logic [3:0] cycles_q;
  logic [3:0] p_q;
  logic       up_down_q;
  logic       load_q;
  logic       ce_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;
  logic [3:0] evt_cnt_q;

  logic [4:0] evt_inc;
  logic [3:0] evt_cnt_d;
  logic       complete_d;
  logic       terminal;

  always_comb begin
    evt_inc    = {1'b0, evt_cnt_q} + 5'd1;
    evt_cnt_d  = (evt_cnt_q == 4'd15) ? 4'd15 : evt_inc[3:0];
    complete_d = (mode_q == MODE_ONESHOT) ||
                 ((cycles_q != 4'd0) && (evt_inc == {1'b0, cycles_q}));
    terminal   = (state_q == S_RUN) && bus.max_min;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_ONESHOT;
      cycles_q  <= 4'd0;
      p_q       <= 4'd0;
      up_down_q <= 1'b0;
      load_q    <= 1'b1;
      ce_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      evt_cnt_q <= 4'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.stop) begin
            if (bus.preset > 4'd9) begin
              err_q <= 1'b1;
            end else begin
              p_q       <= bus.preset;
              up_down_q <= bus.dir;
              mode_q    <= bus.mode;
              cycles_q  <= bus.cycles;
              evt_cnt_q <= 4'd0;
              load_q    <= 1'b0;
              ce_q      <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          load_q <= 1'b1;
          if (bus.stop) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            ce_q    <= 1'b0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          // STOP beats a coincident terminal event, so the event is not counted
          if (bus.stop) begin
            ce_q    <= 1'b1;
            load_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (terminal) begin
            evt_cnt_q <= evt_cnt_d;
            if (complete_d) begin
              ce_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              case (mode_q)
                MODE_PERIODIC: begin
                  load_q  <= 1'b0;
                  ce_q    <= 1'b1;
                  state_q <= S_LOAD;
                end
                MODE_BOUNCE: up_down_q <= ~up_down_q;
                default: ;
              endcase
            end
          end
        end
        S_DONE: begin
          ce_q    <= 1'b1;
          load_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Holding CE high while MAX_MIN is up keeps the counter from wrapping outside FREE mode
  assign bus.ce      = ce_q | (terminal && (mode_q != MODE_FREE));
  assign bus.load    = load_q;
  assign bus.up_down = up_down_q;
  assign bus.p       = p_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.evt_cnt = evt_cnt_q;

endmodule

// File: tb/tb_cnt74190_seq.sv
// tb/tb_cnt74190_seq.sv - bench for cnt74190_seq with a behavioural cnt74190 counter
module tb_cnt74190_seq;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;
  logic [3:0] cnt_q;
  logic [7:0] sq[$];

  cnt74190_seq_if bus ();

  cnt74190_seq dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter plant: parallel load wins over count enable, decade wrap both ways
  initial cnt_q = 4'd0;
  always @(posedge clk) begin
    if (!bus.load)
      cnt_q <= bus.p;
    else if (!bus.ce)
      cnt_q <= bus.up_down ? ((cnt_q == 4'd0) ? 4'd9 : cnt_q - 4'd1)
                           : ((cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1);
  end
  assign bus.q       = cnt_q;
  assign bus.max_min = bus.up_down ? (cnt_q == 4'd0) : (cnt_q == 4'd9);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rec(input int q, input bit ce, input bit ud, input bit done, input bit load);
    logic [3:0] qq;
    qq = q[3:0];
    return {load, done, ud, ce, qq};
  endfunction

  function automatic logic [7:0] obs_rec();
    return {bus.load, bus.done, bus.up_down, bus.ce, bus.q};
  endfunction

  function automatic logic [13:0] out_vec();
    return {bus.load, bus.ce, bus.up_down, bus.p, bus.busy, bus.done, bus.err, bus.evt_cnt};
  endfunction

  // One counting leg from v0 to its terminal; the terminal sample is the CE-gated hold
  task automatic push_leg(input int v0, input bit down);
    int v;
    bit term;
    v = v0;
    for (int k = 0; k < 10; k++) begin
      term = down ? (v == 0) : (v == 9);
      sq.push_back(rec(v, term, down, 1'b0, 1'b1));
      if (term) break;
      v = down ? v - 1 : v + 1;
    end
  endtask

  task automatic run_sc(input string tag, input logic [1:0] m, input bit d, input logic [3:0] pre,
                        input logic [3:0] cyc, input int stop_at, input int poke_at);
    int idx;
    logic [7:0] e;
    idx = 0;
    @(negedge clk);
    bus.mode = m; bus.dir = d; bus.preset = pre; bus.cycles = cyc; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_ldcyc"}, 32'({bus.load, bus.busy, bus.ce}), 32'b011);
    while (sq.size() > 0) begin
      @(negedge clk);
      e = sq.pop_front();
      check(tag, 32'(obs_rec()), 32'(e));
      if (idx == poke_at) begin
        bus.start = 1'b1; bus.mode = 2'b11; bus.dir = ~d; bus.preset = 4'd7; bus.cycles = 4'd1;
      end
      if (idx == poke_at + 1) bus.start = 1'b0;
      if (idx == stop_at) begin
        bus.stop = 1'b1;
        sq.delete();
      end
      idx++;
    end
    bus.start = 1'b0;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dones;
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 2'b00; bus.dir = 1'b0;
    bus.preset = 4'd0; bus.cycles = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", 32'(out_vec()), 32'(14'b11_0_0000_0_0_0_0000));
    rst = 1'b0;

    // ONESHOT up from 0, with START and input changes injected mid-run
    push_leg(0, 1'b0);
    sq.push_back(rec(9, 1'b1, 1'b0, 1'b1, 1'b1));
    run_sc("oneshot", 2'b00, 1'b0, 4'd0, 4'd0, -1, 4);
    check("os_evt", 32'(bus.evt_cnt), 32'd1);
    check("os_idle", 32'({bus.busy, bus.done, bus.ce, bus.load}), 32'b0011);
    check("os_qhold", 32'(bus.q), 32'd9);

    // PERIODIC down from 5, three cycles
    for (int k = 0; k < 3; k++) begin
      push_leg(5, 1'b1);
      sq.push_back((k < 2) ? rec(0, 1'b1, 1'b1, 1'b0, 1'b0) : rec(0, 1'b1, 1'b1, 1'b1, 1'b1));
    end
    run_sc("periodic", 2'b01, 1'b1, 4'd5, 4'd3, -1, -1);
    check("per_evt", 32'(bus.evt_cnt), 32'd3);
    check("per_p_ud", 32'({bus.p, bus.up_down}), 32'({4'd5, 1'b1}));

    // BOUNCE 0<->9, four legs
    push_leg(0, 1'b0); push_leg(9, 1'b1); push_leg(0, 1'b0); push_leg(9, 1'b1);
    sq.push_back(rec(0, 1'b1, 1'b1, 1'b1, 1'b1));
    run_sc("bounce", 2'b10, 1'b0, 4'd0, 4'd4, -1, -1);
    check("bnc_evt", 32'(bus.evt_cnt), 32'd4);

    // FREE wraps with no CE gap, then STOP after 25 cycles
    for (int i = 0; i < 25; i++) sq.push_back(rec(i % 10, 1'b0, 1'b0, 1'b0, 1'b1));
    run_sc("free", 2'b11, 1'b0, 4'd0, 4'd0, 24, -1);
    check("free_stop", 32'({bus.ce, bus.load, bus.busy, bus.done}), 32'b1100);
    check("free_evt", 32'(bus.evt_cnt), 32'd2);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dones += int'(bus.done);
    end
    check("free_nodone", 32'(dones), 32'd0);

    // Invalid preset: single ERR pulse, no run
    @(negedge clk);
    bus.preset = 4'd12; bus.mode = 2'b00; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("err_pulse", 32'({bus.err, bus.busy, bus.load}), 32'b101);
    @(negedge clk);
    check("err_clr", 32'({bus.err, bus.busy, bus.load}), 32'b001);

    // STOP on the same edge as the terminal event
    push_leg(7, 1'b0);
    run_sc("stopterm", 2'b00, 1'b0, 4'd7, 4'd0, 2, -1);
    check("st_evt", 32'(bus.evt_cnt), 32'd0);
    check("st_idle", 32'({bus.ce, bus.busy, bus.done}), 32'b100);

    // RST mid-run
    @(negedge clk);
    bus.mode = 2'b01; bus.dir = 1'b1; bus.preset = 4'd5; bus.cycles = 4'd0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid", 32'(out_vec()), 32'(14'b11_0_0000_0_0_0_0000));
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
